seq_slice_adder: RTL

- Multi-cycle 32-bit adder controller. Reuses one 8-bit ripple slice over 4 consecutive cycles instead of instantiating four slices.
- Latches operands on a valid/ready handshake. Sequences the slices LSB-first, chaining the carry through a register.
- Presents the sum with a valid/ready output handshake.
- Sits between the ALU issue logic and the register writeback as the area-reduced adder option.

---
 rtl/seq_adder_pkg.sv | 18 +
 rtl/byte_add_slice.sv | 27 ++
 rtl/seq_slice_adder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seq_adder_pkg.sv
// Shared types and constants for the slice-serial adder.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

    // A single-slice build still needs a one-bit counter.
    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/byte_add_slice.sv
// Combinational SLICE-bit ripple-carry adder; the only arithmetic in the design.
module byte_add_slice
    import seq_adder_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] sum,
    output logic             co
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = ci;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[SLICE];
    end

endmodule

// File: rtl/seq_slice_adder.sv
// Multi-cycle adder: one SLICE-bit slice reused LSB-first, carry chained through a register.
// Optional subtract mode (sub input, ovf output) enabled by defining SEQ_SLICE_ADDER_SUB_EN.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   RUN   | one slice per cycle, counter selects the slice
//   DONE  | result presented, held until out_ready
module seq_slice_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy
`ifdef SEQ_SLICE_ADDER_SUB_EN
    ,
    input  logic             sub,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = cnt_width(NSLICE);

    state_t                        state_q, state_d;
    logic [NSLICE-1:0][SLICE-1:0]  x_q, x_d;
    logic [NSLICE-1:0][SLICE-1:0]  y_q, y_d;
    logic [NSLICE-1:0][SLICE-1:0]  s_q, s_d;
    logic                          carry_q, carry_d;
    logic                          cout_q, cout_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [SLICE-1:0]              slice_sum;
    logic                          slice_co;
    logic                          last_slice;

    byte_add_slice #(.SLICE(SLICE)) u_slice (
        .a   (x_q[cnt_q]),
        .b   (y_q[cnt_q]),
        .ci  (carry_q),
        .sum (slice_sum),
        .co  (slice_co)
    );

    assign last_slice = (cnt_q == CW'(NSLICE - 1));

`ifdef SEQ_SLICE_ADDER_SUB_EN
    logic ovf_q, ovf_d;
    logic msb_cin;

    // Carry into the MSB recovered from the final slice's top sum bit.
    assign msb_cin = slice_sum[SLICE-1] ^ x_q[cnt_q][SLICE-1] ^ y_q[cnt_q][SLICE-1];
    assign ovf     = ovf_q;
`endif

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        s_d       = s_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
`ifdef SEQ_SLICE_ADDER_SUB_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_d     = x;
`ifdef SEQ_SLICE_ADDER_SUB_EN
                    y_d     = sub ? ~y : y;
                    carry_d = sub ? 1'b1 : cin;
`else
                    y_d     = y;
                    carry_d = cin;
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                s_d[cnt_q] = slice_sum;
                carry_d    = slice_co;
                cnt_d      = cnt_q + CW'(1);
                if (last_slice) begin
                    cout_d  = slice_co;
                    state_d = DONE;
`ifdef SEQ_SLICE_ADDER_SUB_EN
                    ovf_d   = msb_cin ^ slice_co;
`endif
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SEQ_SLICE_ADDER_SUB_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SEQ_SLICE_ADDER_SUB_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

endmodule
